// File: rtl/memory_arbiter_pkg.sv
// Shared types for the two-port memory arbiter.
// FSM states, port ids and the word width.
package memory_arbiter_pkg;

  localparam int WORD_W = 32;

  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  typedef struct packed {
    logic              port;
    logic              we;
    logic [WORD_W-1:0] adr;
    logic [WORD_W-1:0] wdata;
  } req_t;

endpackage

// File: rtl/memory_arbiter_grant.sv
// Grant selection between instruction and data requesters.
// i_pref names the port that wins when both request.
module arbiter_grant
  import memory_arbiter_pkg::*;
(
  input  logic i_ireq,
  input  logic i_dreq,
  input  logic i_pref,
  output logic o_valid,
  output logic o_port
);

  always_comb begin
    o_valid = i_ireq | i_dreq;
    o_port  = PORT_D;
    if (i_ireq && i_dreq) begin
      o_port = i_pref;
    end else if (i_ireq) begin
      o_port = PORT_I;
    end
  end

endmodule

// File: rtl/memory_arbiter.sv
// Single-RAM arbiter for instruction and data ports.
// Define ARBITER_ROUND_ROBIN_EN for round-robin ties.
module memory_arbiter
  import memory_arbiter_pkg::*;
#(
  parameter int RAM_SIZE = 4096
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              i_req,
  input  logic [WORD_W-1:0] i_adr,
  output logic              i_ready,
  output logic [WORD_W-1:0] i_rdata,
  output logic              i_rvalid,
  output logic              i_err,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [WORD_W-1:0] d_adr,
  input  logic [WORD_W-1:0] d_wdata,
  output logic              d_ready,
  output logic [WORD_W-1:0] d_rdata,
  output logic              d_rvalid,
  output logic              d_err,
  output logic [WORD_W-1:0] ram_radr,
  output logic [WORD_W-1:0] ram_wadr,
  output logic [WORD_W-1:0] ram_wvalue,
  output logic              ram_wenable,
  input  logic [WORD_W-1:0] ram_rvalue
);

  localparam logic [WORD_W-1:0] LIMIT =
    WORD_W'(RAM_SIZE);

  state_t            r_state;
  state_t            w_next;
  req_t              r_req;
  req_t              w_sel;
  logic [WORD_W-1:0] r_rdata;
  logic              w_pref;
  logic              w_gnt_valid;
  logic              w_gnt_port;
  logic              w_grant;
  logic              w_oor;
  logic              w_done;

  arbiter_grant u_grant (
    .i_ireq  (i_req),
    .i_dreq  (d_req),
    .i_pref  (w_pref),
    .o_valid (w_gnt_valid),
    .o_port  (w_gnt_port)
  );

`ifdef ARBITER_ROUND_ROBIN_EN
  logic r_pref;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_pref <= PORT_D;
    end else if (w_grant) begin
      r_pref <= ~w_gnt_port;
    end
  end

  assign w_pref = r_pref;
`else
  assign w_pref = PORT_D;
`endif

  assign w_grant = w_gnt_valid && !reset &&
                   (r_state != ACCESS);

  assign w_oor = (r_req.adr >= LIMIT);

  // instruction side never writes
  always_comb begin
    w_sel.port  = w_gnt_port;
    w_sel.we    = 1'b0;
    w_sel.adr   = i_adr;
    w_sel.wdata = '0;
    if (w_gnt_port == PORT_D) begin
      w_sel.we    = d_we;
      w_sel.adr   = d_adr;
      w_sel.wdata = d_wdata;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE, DONE: begin
        w_next = w_grant ? ACCESS : IDLE;
      end
      ACCESS: begin
        w_next = DONE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_req <= '0;
    end else if (w_grant) begin
      r_req <= w_sel;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_rdata <= '0;
    end else if (r_state == ACCESS) begin
      r_rdata <= (w_oor || r_req.we) ?
                 '0 : ram_rvalue;
    end
  end

  assign w_done = (r_state == DONE) && !reset;

  assign i_ready  = w_grant &&
                    (w_gnt_port == PORT_I);
  assign d_ready  = w_grant &&
                    (w_gnt_port == PORT_D);

  assign i_rvalid = w_done &&
                    (r_req.port == PORT_I);
  assign d_rvalid = w_done &&
                    (r_req.port == PORT_D);
  assign i_err    = i_rvalid && w_oor;
  assign d_err    = d_rvalid && w_oor;
  assign i_rdata  = r_rdata;
  assign d_rdata  = r_rdata;

  assign ram_radr    = r_req.adr;
  assign ram_wadr    = r_req.adr;
  assign ram_wvalue  = r_req.wdata;
  assign ram_wenable = (r_state == ACCESS) &&
                       r_req.we && !w_oor &&
                       !reset;

endmodule
